seven_seg_scan_ctrl: RTL

//  Scan controller for an N-digit multiplexed common-anode seven-segment display.
//  - Derives the per-digit refresh slot from the system clock.
//  - Inserts a blanking dead-time between digits (anti-ghosting) and decodes hex nibbles.
//  - Double-buffers the displayed value so updates land only on frame boundaries (no tearing).
//  - Sits between CPU-visible result registers and the board's segment/anode pins.

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/hex_to_seg7.sv | 13 +
 rtl/seven_seg_scan_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   - scan_state_e : two-state slot FSM encoding (ST_BLANK, ST_SHOW)
//   - SEG_BLANK    : all segments off (active-low)
//   - GLYPH        : 16-entry hex glyph table, {g,f,e,d,c,b,a}, active-low,
//                    lowercase b and d so they differ from 8 and 0
package seg7_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble -> active-low seven-segment decoder.
//   nibble : in  4  hex digit
//   seg    : out 7  {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = GLYPH[nibble];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for an N-digit multiplexed common-anode seven-segment display.
// Each digit gets an equal slot of CLK_DIV cycles; the first BLANK_CYCLES of every
// slot keep all anodes off to suppress ghosting. The displayed value is held in a
// shadow register that only changes on frame boundaries, so a frame never tears.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   value      in   4*NUM_DIGITS hex nibbles, digit 0 rightmost
//   dp_in      in   decimal point per digit, 1 = lit
//   digit_en   in   per-digit enable, sampled live
//   load       in   1-cycle strobe capturing value/dp_in for the next frame
//   seg        out  {g,f,e,d,c,b,a}, active-low
//   dp         out  decimal point, active-low
//   an         out  anodes, active-low
//   frame_done out  pulse in the last cycle of the last digit slot
//
// Build option: define SEVSEG_LZB_EN for leading-zero blanking.
module seven_seg_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  scan_state_e   state_q, state_d;
  logic          slot_end, frame_end;

  assign slot_end  = (cnt == CW'(CLK_DIV - 1));
  assign frame_end = slot_end && (idx == IW'(NUM_DIGITS - 1));

  // Slot counter and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= frame_end ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BLANK;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt == CW'(BLANK_CYCLES - 1)) state_d = ST_SHOW;
      ST_SHOW:  if (slot_end) state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase
  end

  // Staging / shadow double buffer. The swap is keyed off the registered
  // frame_done so a load seen alongside the frame_done pin takes the bypass.
  // That cycle is always in BLANK (BLANK_CYCLES >= 1), so the shadow is never
  // read while it changes.
  logic [4*NUM_DIGITS-1:0] stg_val, shd_val;
  logic [NUM_DIGITS-1:0]   stg_dp, shd_dp;
  logic                    pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_val <= '0;
      stg_dp  <= '0;
      shd_val <= '0;
      shd_dp  <= '0;
      pending <= 1'b0;
    end else begin
      if (load) begin
        stg_val <= value;
        stg_dp  <= dp_in;
      end
      if (frame_done) begin
        if (load) begin
          shd_val <= value;
          shd_dp  <= dp_in;
          pending <= 1'b0;
        end else if (pending) begin
          shd_val <= stg_val;
          shd_dp  <= stg_dp;
          pending <= 1'b0;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Leading-zero mask: digit i set when it and every digit above it are zero.
  logic [NUM_DIGITS-1:0] lead_zero;
`ifdef SEVSEG_LZB_EN
  logic lz_run;
  always_comb begin
    lead_zero = '0;
    lz_run    = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_run       = lz_run && (shd_val[4*i +: 4] == 4'h0);
      lead_zero[i] = lz_run;
    end
  end
`else
  assign lead_zero = '0;
`endif

  logic [3:0] nib;
  logic [6:0] glyph;

  assign nib = shd_val[{idx, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (nib),
    .seg    (glyph)
  );

  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;
  logic                  dp_d;

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (state_q == ST_SHOW) begin
      dp_d = ~shd_dp[idx];
      if (!lead_zero[idx]) begin
        seg_d = glyph;
        if (digit_en[idx]) an_d[idx] = 1'b0;
      end
    end
  end

  // Registered pins: they trail the counter/state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= '1;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_done <= frame_end;
    end
  end

endmodule
